// File: rtl/arb_pkg.sv
// Shared types and constants for the N-way bus arbiter.
//   arb_state_e : arbiter FSM state (IDLE, GRANT)
//   ARB_FIXED   : mode value selecting fixed priority (bit 0 highest)
//   ARB_RR      : mode value selecting round-robin
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam logic ARB_FIXED = 1'b0;
   localparam logic ARB_RR    = 1'b1;

endpackage

// File: rtl/arb_prio_pick.sv
// Combinational lowest-index-first picker.
// Ports:
//   req_i   [N-1:0]  candidate request vector
//   gnt_o   [N-1:0]  one-hot lowest set bit of req_i (zero if none)
//   valid_o          1 when any bit of req_i is set
module arb_prio_pick
   import arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] req_i,
   output logic [N-1:0] gnt_o,
   output logic         valid_o
);

   logic found;

   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (req_i[i] && !found) begin
            gnt_o[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end

   assign valid_o = |req_i;

endmodule

// File: rtl/arbiter_rr_n.sv
// N-requester bus arbiter with fixed-priority or round-robin selection and a
// registered one-hot grant. A grant is held while its own request stays high;
// on release the next winner is granted directly with no idle cycle.
// Optional feature macro: ARB_TIMEOUT_EN -- bounds a tenure to HOLD_MAX cycles
// whenever another request is waiting.
// Ports:
//   Clock   in   1   rising-edge clock
//   Resetn  in   1   synchronous active-low reset
//   r       in   N   request vector, bit 0 = requester 0
//   mode    in   1   ARB_FIXED (0) or ARB_RR (1), sampled at selection points
//   g       out  N   one-hot grant, registered, zero when idle
//   gid     out  IW  index of current holder, 0 when idle
//   busy    out  1   any grant active
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no grant; any request is arbitrated on the next edge
// GRANT | g_q/holder_q own the resource; last_q == holder_q
module arbiter_rr_n
   import arb_pkg::*;
#(
   parameter  int N        = 4,
   parameter  int HOLD_MAX = 8,
   localparam int IW       = $clog2(N)
) (
   input  logic          Clock,
   input  logic          Resetn,
   input  logic [N-1:0]  r,
   input  logic          mode,
   output logic [N-1:0]  g,
   output logic [IW-1:0] gid,
   output logic          busy
);

   if (N < 2 || N > 16 || HOLD_MAX < 2) begin : g_param_check
      $error("arbiter_rr_n: N must be 2..16 and HOLD_MAX >= 2");
   end

   arb_state_e    state_q, state_d;
   logic [N-1:0]  g_q, g_d;
   logic [IW-1:0] holder_q, holder_d;
   logic [IW-1:0] last_q, last_d;

   logic [N-1:0]  cand;
   logic [N-1:0]  above_last;
   logic [N-1:0]  pick_masked, pick_full, win_oh;
   logic          valid_masked, valid_full;
   logic [IW-1:0] win_idx;
   logic          holder_req;
   logic          take_win;

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(HOLD_MAX);
   logic [CW-1:0] cnt_q, cnt_d;
`endif

   // g_q is zero in IDLE, so this both passes all requests when idle and
   // drops the holder from the hand-off pick when granted.
   assign cand       = r & ~g_q;
   assign holder_req = |(r & g_q);

   always_comb begin
      above_last = '0;
      for (int i = 0; i < N; i++) begin
         above_last[i] = (IW'(i) > last_q);
      end
   end

   arb_prio_pick #(.N(N)) u_pick_masked (
      .req_i   (cand & above_last),
      .gnt_o   (pick_masked),
      .valid_o (valid_masked)
   );

   arb_prio_pick #(.N(N)) u_pick_full (
      .req_i   (cand),
      .gnt_o   (pick_full),
      .valid_o (valid_full)
   );

   // Round-robin: bits above last first, then wrap to the lowest set bit.
   assign win_oh = (mode == ARB_RR && valid_masked) ? pick_masked : pick_full;

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (win_oh[i]) begin
            win_idx = win_idx | IW'(i);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      g_d      = g_q;
      holder_d = holder_q;
      last_d   = last_q;
      take_win = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_d    = cnt_q;
`endif

      case (state_q)
         IDLE: begin
            if (valid_full) begin
               take_win = 1'b1;
            end
         end
         GRANT: begin
            if (holder_req) begin
`ifdef ARB_TIMEOUT_EN
               // cnt_q counts completed grant cycles minus one, so the
               // HOLD_MAX-th visible cycle is the revoke point.
               if (cnt_q == CW'(HOLD_MAX - 1)) begin
                  if (valid_full) begin
                     take_win = 1'b1;
                  end else begin
                     cnt_d = '0;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
`endif
            end else if (valid_full) begin
               take_win = 1'b1;
            end else begin
               state_d  = IDLE;
               g_d      = '0;
               holder_d = '0;
            end
         end
         default: begin
            state_d  = IDLE;
            g_d      = '0;
            holder_d = '0;
         end
      endcase

      if (take_win) begin
         state_d  = GRANT;
         g_d      = win_oh;
         holder_d = win_idx;
         last_d   = win_idx;
`ifdef ARB_TIMEOUT_EN
         cnt_d    = '0;
`endif
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q  <= IDLE;
         g_q      <= '0;
         holder_q <= '0;
         last_q   <= IW'(N - 1);
`ifdef ARB_TIMEOUT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         g_q      <= g_d;
         holder_q <= holder_d;
         last_q   <= last_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign g    = g_q;
   assign gid  = holder_q;
   assign busy = |g_q;

endmodule

// File: tb/tb_arbiter_rr_n.sv
module tb_arbiter_rr_n;

   localparam int N        = 4;
   localparam int HOLD_MAX = 8;

   logic       Clock = 1'b0;
   logic       Resetn;
   logic [3:0] r;
   logic       mode;
   logic [3:0] g;
   logic [1:0] gid;
   logic       busy;

   int errors = 0;
   int checks = 0;

   // Reference state: holder index (-1 = idle), round-robin pointer and the
   // number of cycles the current grant has been visible.
   int m_holder = -1;
   int m_last   = N - 1;
   int m_held   = 0;

   always #5 Clock = ~Clock;

   arbiter_rr_n #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .r      (r),
      .mode   (mode),
      .g      (g),
      .gid    (gid),
      .busy   (busy)
   );

   function automatic int pick(input logic [3:0] req, input logic md, input int lst);
      if (md) begin
         for (int k = 1; k <= N; k++) begin
            if (req[(lst + k) % N]) return (lst + k) % N;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (req[i]) return i;
         end
      end
      return -1;
   endfunction

   task automatic model_step(input logic [3:0] rv, input logic md, input logic rst);
      int w;
      logic [3:0] others;
      w = -1;
      if (!rst) begin
         m_holder = -1;
         m_last   = N - 1;
         m_held   = 0;
         return;
      end
      if (m_holder < 0) begin
         w = pick(rv, md, m_last);
      end else if (rv[m_holder]) begin
`ifdef ARB_TIMEOUT_EN
         if (m_held >= HOLD_MAX) begin
            others = rv;
            others[m_holder] = 1'b0;
            w = pick(others, md, m_last);
            if (w < 0) m_held = 1;
         end else begin
            m_held++;
         end
`else
         others = rv;
`endif
      end else begin
         w = pick(rv, md, m_last);
         if (w < 0) m_holder = -1;
      end
      if (w >= 0) begin
         m_holder = w;
         m_last   = w;
         m_held   = 1;
      end
   endtask

   task automatic cycle(input logic [3:0] rv, input logic md, input logic rst);
      logic [3:0] exp_g;
      logic [1:0] exp_gid;
      logic       exp_busy;
      r      = rv;
      mode   = md;
      Resetn = rst;
      @(posedge Clock);
      model_step(rv, md, rst);
      #1;
      exp_g    = (m_holder < 0) ? 4'b0000 : 4'(1 << m_holder);
      exp_gid  = (m_holder < 0) ? 2'd0 : 2'(m_holder);
      exp_busy = (m_holder >= 0);
      checks++;
      assert (g === exp_g) else begin
         errors++;
         $error("FAIL g: observed %b expected %b (r=%b mode=%b)", g, exp_g, rv, md);
      end
      checks++;
      assert (gid === exp_gid) else begin
         errors++;
         $error("FAIL gid: observed %0d expected %0d", gid, exp_gid);
      end
      checks++;
      assert (busy === exp_busy) else begin
         errors++;
         $error("FAIL busy: observed %b expected %b", busy, exp_busy);
      end
   endtask

   task automatic expect_g(input string tag, input logic [3:0] e);
      checks++;
      assert (g === e) else begin
         errors++;
         $error("FAIL %s: observed g=%b expected g=%b", tag, g, e);
      end
   endtask

   initial begin
      logic [3:0] rv;
      logic       md;
      logic       rst;

      // Reset state
      cycle(4'b0000, 1'b0, 1'b0);
      cycle(4'b0000, 1'b0, 1'b0);
      expect_g("reset", 4'b0000);

      // Fixed priority, held while r[1] stays high, then direct hand-off
      cycle(4'b0110, 1'b0, 1'b1);
      expect_g("fixed_first", 4'b0010);
      for (int i = 0; i < 3; i++) cycle(4'b0110, 1'b0, 1'b1);
      expect_g("fixed_hold", 4'b0010);
      cycle(4'b0100, 1'b0, 1'b1);
      expect_g("handoff", 4'b0100);
      cycle(4'b0000, 1'b0, 1'b1);
      expect_g("release_idle", 4'b0000);

      // Round-robin order 0,1,2,3,0 with one-cycle pulses
      cycle(4'b0000, 1'b1, 1'b0);
      cycle(4'b1111, 1'b1, 1'b1);
      expect_g("rr_0", 4'b0001);
      cycle(4'b1111, 1'b1, 1'b1);
      cycle(4'b1110, 1'b1, 1'b1);
      expect_g("rr_1", 4'b0010);
      cycle(4'b1111, 1'b1, 1'b1);
      cycle(4'b1101, 1'b1, 1'b1);
      expect_g("rr_2", 4'b0100);
      cycle(4'b1111, 1'b1, 1'b1);
      cycle(4'b1011, 1'b1, 1'b1);
      expect_g("rr_3", 4'b1000);
      cycle(4'b1111, 1'b1, 1'b1);
      cycle(4'b0111, 1'b1, 1'b1);
      expect_g("rr_wrap_0", 4'b0001);

      // Wrap from last=3 via hand-off, then idle
      cycle(4'b1000, 1'b1, 1'b1);
      expect_g("rr_to_3", 4'b1000);
      cycle(4'b0001, 1'b1, 1'b1);
      expect_g("rr_wrap_handoff", 4'b0001);
      cycle(4'b0000, 1'b1, 1'b1);
      expect_g("rr_idle", 4'b0000);

      // Reset mid-tenure, then round-robin restarts from last=N-1
      cycle(4'b1000, 1'b1, 1'b1);
      cycle(4'b1000, 1'b1, 1'b1);
      cycle(4'b1000, 1'b1, 1'b0);
      expect_g("reset_mid_tenure", 4'b0000);
      cycle(4'b0000, 1'b1, 1'b1);
      cycle(4'b1001, 1'b1, 1'b1);
      expect_g("rr_after_reset", 4'b0001);
      cycle(4'b0000, 1'b1, 1'b1);

      // Constant contention: unbounded hold, or HOLD_MAX alternation
      for (int i = 0; i < 4 * HOLD_MAX + 3; i++) cycle(4'b0011, 1'b0, 1'b1);
`ifndef ARB_TIMEOUT_EN
      expect_g("unbounded_hold", 4'b0001);
`endif
      cycle(4'b0000, 1'b0, 1'b1);

      // Randomized traffic with sticky request bits, mode flips and resets
      rv = 4'b0000;
      md = 1'b0;
      for (int i = 0; i < 600; i++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 3) == 0) rv[b] = ~rv[b];
         end
         if ($urandom_range(0, 15) == 0) md = ~md;
         rst = ($urandom_range(0, 63) != 0);
         cycle(rv, md, rst);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
